// File: rtl/bin_to_dec_seq.sv
// bin_to_dec_seq: sequential double-dabble binary-to-BCD converter.
// One binary bit is consumed per clock; three BCD digits are registered on
// completion and decoded to active-low seven-segment patterns.
module bin_to_dec_seq #(
  parameter int WIDTH    = 8,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] V,
  output logic             Busy,
  output logic             Done,
  output logic [3:0]       Ones,
  output logic [3:0]       Tens,
  output logic [3:0]       Hundreds,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2
);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Conversion working registers: binary shifter, BCD accumulator, bit counter.
  logic [WIDTH-1:0] bin;
  logic [11:0]      bcd;
  logic [3:0]       cnt;

  logic [11:0]      bcd_adj;
  logic [11:0]      bcd_sh;
  logic [WIDTH-1:0] bin_sh;

  logic load;
  logic step;
  logic finish;

  // Add 3 to a BCD field holding 5 or more, so the following doubling carries
  // correctly into the next decimal digit.
  function automatic logic [3:0] add3_adjust(input logic [3:0] d);
    if (d >= 4'd5)
      return d + 4'd3;
    else
      return d;
  endfunction

  // Active-low segment pattern {g..a}; codes 10..15 and forced blanking
  // both produce an all-off display.
  function automatic logic [6:0] seg7(input logic [3:0] d, input logic blank);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    if (blank)
      s = 7'b1111111;
    return s;
  endfunction

  // Adjust uses the pre-shift fields, then the whole {bcd, bin} word moves
  // left by one; the hundreds carry-out is dropped since 511 fits in 3 digits.
  assign bcd_adj = {add3_adjust(bcd[11:8]), add3_adjust(bcd[7:4]), add3_adjust(bcd[3:0])};
  assign bcd_sh  = 12'({bcd_adj, bin[WIDTH-1]});
  assign bin_sh  = bin << 1;

  assign Busy = (state == CONV);

  // Next-state and step control for the IDLE/CONV controller.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          load      = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (cnt == 4'd1) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset wins over any pending Start.
  always_ff @(posedge Clock) begin
    if (Reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Bit counter and Done pulse; an aborted conversion never reaches finish.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt  <= 4'd0;
      Done <= 1'b0;
    end else begin
      Done <= finish;
      if (load)
        cnt <= 4'(WIDTH);
      else if (step)
        cnt <= cnt - 4'd1;
    end
  end

  // Shifter and accumulator carry data only; they are reloaded on every start.
  always_ff @(posedge Clock) begin
    if (load) begin
      bin <= V;
      bcd <= 12'd0;
    end else if (step) begin
      bin <= bin_sh;
      bcd <= bcd_sh;
    end
  end

  // Result digits update only on the completing edge so the display never
  // shows partial values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Hundreds <= 4'd0;
      Tens     <= 4'd0;
      Ones     <= 4'd0;
    end else if (finish) begin
      Hundreds <= bcd_sh[11:8];
      Tens     <= bcd_sh[7:4];
      Ones     <= bcd_sh[3:0];
    end
  end

  // Segment decode of the registered digits with optional leading-zero blanking.
  assign HEX0 = seg7(Ones, 1'b0);
  assign HEX1 = seg7(Tens, BLANK_LZ && (Hundreds == 4'd0) && (Tens == 4'd0));
  assign HEX2 = seg7(Hundreds, BLANK_LZ && (Hundreds == 4'd0));

endmodule

// File: tb/tb_bin_to_dec_seq.sv
// tb_bin_to_dec_seq: directed vectors for bin_to_dec_seq at default parameters.
module tb_bin_to_dec_seq;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] V;
  logic       Busy;
  logic       Done;
  logic [3:0] Ones, Tens, Hundreds;
  logic [6:0] HEX0, HEX1, HEX2;

  int n_checks = 0;
  int n_errors = 0;

  bin_to_dec_seq #(.WIDTH(8), .BLANK_LZ(1'b1)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .V        (V),
    .Busy     (Busy),
    .Done     (Done),
    .Ones     (Ones),
    .Tens     (Tens),
    .Hundreds (Hundreds),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".busy"}, 32'(Busy), 32'd0);
    check({tag, ".done"}, 32'(Done), 32'd0);
    check({tag, ".digits"}, {20'd0, Hundreds, Tens, Ones}, 32'h000);
    check({tag, ".hex0"}, 32'(HEX0), 32'(S0));
    check({tag, ".hex1"}, 32'(HEX1), 32'(SB));
    check({tag, ".hex2"}, 32'(HEX2), 32'(SB));
  endtask

  task automatic check_result(input string tag, input logic [11:0] dig,
                              input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
    check({tag, ".digits"}, {20'd0, Hundreds, Tens, Ones}, {20'd0, dig});
    check({tag, ".hex2"}, 32'(HEX2), 32'(e2));
    check({tag, ".hex1"}, 32'(HEX1), 32'(e1));
    check({tag, ".hex0"}, 32'(HEX0), 32'(e0));
  endtask

  // Wait (bounded) for Done after an accepting edge; returns cycles elapsed.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!Done && lat < 20) begin
      tick();
      lat++;
      if (lat == 7)
        check("busy_last_conv_cycle", 32'(Busy), 32'd1);
    end
  endtask

  // Single conversion: Start pulse, latency, result, then hold after Done.
  task automatic convert(input string tag, input logic [7:0] v, input logic [11:0] dig,
                         input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
    int lat;
    V = v;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check({tag, ".busy_after_start"}, 32'(Busy), 32'd1);
    wait_done(lat);
    check({tag, ".latency"}, 32'(lat), 32'd8);
    check({tag, ".busy_in_done"}, 32'(Busy), 32'd0);
    check_result(tag, dig, e2, e1, e0);
    tick();
    check({tag, ".done_one_cycle"}, 32'(Done), 32'd0);
    check({tag, ".digits_hold"}, {20'd0, Hundreds, Tens, Ones}, {20'd0, dig});
  endtask

  initial begin
    int lat;
    int ndone;
    int done_at;

    // Reset held two cycles with Start asserted.
    Reset = 1'b1;
    Start = 1'b1;
    V = 8'd77;
    tick();
    tick();
    check_reset_outputs("reset");
    Reset = 1'b0;
    Start = 1'b0;
    tick();
    check("idle_after_reset.busy", 32'(Busy), 32'd0);
    check("idle_after_reset.done", 32'(Done), 32'd0);

    // Maximum value and the add-3 boundary on a single digit.
    convert("v255", 8'd255, 12'h255, S2, S5, S5);
    convert("v10", 8'd10, 12'h010, SB, S1, S0);
    convert("v9", 8'd9, 12'h009, SB, SB, S9);

    // Start during conversion is ignored and V changes have no effect.
    V = 8'd100;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    ndone = 0;
    done_at = -1;
    for (int c = 1; c <= 16; c++) begin
      if (c == 3) begin
        Start = 1'b1;
        V = 8'd7;
      end else begin
        Start = 1'b0;
      end
      tick();
      if (Done) begin
        ndone++;
        if (done_at < 0) begin
          done_at = c;
          check_result("v100_ignored_start", 12'h100, S1, S0, S0);
        end
      end
    end
    check("ignored_start.done_count", 32'(ndone), 32'd1);
    check("ignored_start.done_cycle", 32'(done_at), 32'd8);
    check("ignored_start.idle", 32'(Busy), 32'd0);

    // Back-to-back with Start held; the next value is presented in the Done cycle.
    V = 8'd128;
    Start = 1'b1;
    tick();
    wait_done(lat);
    check("b2b_first.latency", 32'(lat), 32'd8);
    check_result("b2b_first", 12'h128, S1, S2, S8);
    V = 8'd64;
    tick();
    check("b2b_second.accepted", 32'(Busy), 32'd1);
    check("b2b_second.first_digits_hold", {20'd0, Hundreds, Tens, Ones}, 32'h128);
    wait_done(lat);
    Start = 1'b0;
    check("b2b_second.latency", 32'(lat), 32'd8);
    check_result("b2b_second", 12'h064, SB, S6, S4);
    tick();

    // Reset in the middle of a conversion aborts it without a Done.
    V = 8'd199;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_reset_outputs("mid_reset");
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (Done)
        ndone++;
    end
    check("mid_reset.no_done", 32'(ndone), 32'd0);
    check("mid_reset.idle", 32'(Busy), 32'd0);
    convert("v42", 8'd42, 12'h042, SB, S4, S2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
